alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle execute controller that owns a 16-entry × 16-bit register file and sequences the team's combinational 16-bit ALU. It accepts one instruction at a time over a valid/ready handshake, reads operands, drives the ALU's A, B and Opcode inputs, and writes C back to the register file. It also latches Carry/Flag/Low/Negative/Zero into a processor status register (PSR). It sits between the instruction fetch/decode logic and the ALU.

## Interface
- REGS, 16: number of registers (address width 4).
- WIDTH, 16: datapath width (must match ALU).
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_opcode  in  8  ALU opcode, forwarded unchanged.
- instr_rdest  in  4  destination register; also supplies operand A.
- instr_rsrc  in  4  source register; supplies operand B when instr_imm=0.
- instr_imm  in  1  1: operand B = sign-extended instr_immval.
- instr_immval  in  8  immediate value.
- instr_wb  in  1  1: write ALU result to rdest (0 for compare-type ops).
- instr_ld  in  1  1: load sign-extended immediate into rdest, bypassing the ALU; PSR unchanged.
- alu_a, alu_b  out  16  ALU operands.
- alu_opcode  out  8  ALU opcode.
- alu_c  in  16  ALU result.
- alu_carry, alu_flag, alu_low, alu_negative, alu_zero  in  1 each  ALU flags.
- psr  out  5  {C,F,L,N,Z} latched flags.
- done  out  1  one-cycle pulse when an instruction retires.
- dbg_addr  in  4  debug read address.
- dbg_data  out  16  combinational read of register dbg_addr.

## Operation
- States: IDLE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid & instr_ready at a clock edge:
  - latch opcode, rdest, wb and ld.
  - latch opA = R[rdest].
  - latch opB = instr_imm ? {{8{immval[7]}},immval} : R[rsrc].
  - go to EXEC.
- instr_ld accepted: latch sign-extended immval as result, go to EXEC; the ALU outputs are ignored.
- EXEC: alu_a=opA, alu_b=opB, alu_opcode=latched opcode; ready=0. Next edge: capture alu_c and the five flags into internal result/flag registers, go to WB.
- WB: done=1, ready=0. At the edge:
  - write the result to R[rdest] if wb or ld.
  - load the captured flags into psr unless ld.
  - go to IDLE.
- Outside EXEC, alu_a/alu_b/alu_opcode hold their last driven values; they are 0 after reset.
- Operands are read at the accept edge. The previous write completes on the WB edge, which is strictly earlier, so no forwarding is needed.
- rdest==rsrc is legal; both operands read the same value.
- Inputs other than valid are ignored when not accepted.

## Timing
- Reset values: all R[i]=0, psr=0, done=0, instr_ready=1 (state IDLE), alu_a=alu_b=0, alu_opcode=0.
- Reset asserted in any state: returns immediately to IDLE. Any in-flight write and PSR update is dropped.
- Accept at edge N → EXEC during cycle N..N+1 → done high for the cycle after edge N+1 → register and PSR update at edge N+2, with instr_ready=1 from then on.
- Throughput: one instruction per 3 cycles. instr_ready is low in EXEC and WB.
- done is never high on two consecutive cycles.
- dbg_data reflects a write from the cycle after the write edge.
- Arithmetic is modulo 2^16, done entirely by the ALU. The sequencer never modifies C or the flags.

## Test plan
- Reset: R[0..15]=0, psr=0, instr_ready=1, done=0. Assert reset during EXEC of a ld R3←0x7F → R3 stays 0, state IDLE.
- Load then add:
  - ld R1←0x45, ld R2←0x80 (sign-extends to 0xFF80).
  - ADD rdest=R1, rsrc=R2, wb=1 → R1=0xFFC5, psr N=1, Z=0, C=0.
  - done pulses exactly 2 cycles after each accept.
- Immediate: R4=0x0001, ADD R4 with imm=0xFF (−1) → R4=0x0000, psr Z=1, C=1.
- Compare (wb=0): R5=0x0010, R6=0x0020, CMP-type op → R5 unchanged, psr equals the ALU flags for that op (L=1).
- Handshake: instr_valid held high continuously for 4 instructions → exactly one accept per 3 cycles, in order, with the final register values matching sequential execution.
- rdest==rsrc: R7=0x4000, ADD R7,R7 → R7=0x8000, N=1, Z=0, C=0.

Source files
------------

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle execute controller: register file, ALU operand sequencing, PSR.
// Three-state sequencer (IDLE/EXEC/WB); all outputs are registered except the debug read port.
module alu_sequencer #(
  parameter int REGS  = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [7:0]               instr_opcode,
  input  logic [$clog2(REGS)-1:0]  instr_rdest,
  input  logic [$clog2(REGS)-1:0]  instr_rsrc,
  input  logic                     instr_imm,
  input  logic [7:0]               instr_immval,
  input  logic                     instr_wb,
  input  logic                     instr_ld,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [7:0]               alu_opcode,
  input  logic [WIDTH-1:0]         alu_c,
  input  logic                     alu_carry,
  input  logic                     alu_flag,
  input  logic                     alu_low,
  input  logic                     alu_negative,
  input  logic                     alu_zero,
  output logic [4:0]               psr,
  output logic                     done,
  input  logic [$clog2(REGS)-1:0]  dbg_addr,
  output logic [WIDTH-1:0]         dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t                    state;
  logic [WIDTH-1:0]          regs [REGS];
  logic [$clog2(REGS)-1:0]   rdest_q;
  logic                      wb_q;
  logic                      ld_q;
  logic [WIDTH-1:0]          result_q;
  logic [4:0]                flags_q;
  logic [WIDTH-1:0]          imm_ext;

  assign imm_ext  = {{(WIDTH-8){instr_immval[7]}}, instr_immval};
  assign dbg_data = regs[dbg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      rdest_q     <= '0;
      wb_q        <= 1'b0;
      ld_q        <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      psr         <= '0;
      for (int i = 0; i < REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            // Operands are sampled here; the previous writeback already landed on an earlier edge.
            alu_a       <= regs[instr_rdest];
            alu_b       <= instr_imm ? imm_ext : regs[instr_rsrc];
            alu_opcode  <= instr_opcode;
            rdest_q     <= instr_rdest;
            wb_q        <= instr_wb;
            ld_q        <= instr_ld;
            result_q    <= imm_ext;
            instr_ready <= 1'b0;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (!ld_q) result_q <= alu_c;
          flags_q <= {alu_carry, alu_flag, alu_low, alu_negative, alu_zero};
          done    <= 1'b1;
          state   <= WB;
        end
        WB: begin
          if (wb_q || ld_q) regs[rdest_q] <= result_q;
          if (!ld_q) psr <= flags_q;
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          done        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench for alu_sequencer with a small behavioural ALU.
module tb_alu_sequencer;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_CMP = 8'h02;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [7:0]  instr_opcode = '0;
  logic [3:0]  instr_rdest = '0;
  logic [3:0]  instr_rsrc = '0;
  logic        instr_imm = 1'b0;
  logic [7:0]  instr_immval = '0;
  logic        instr_wb = 1'b0;
  logic        instr_ld = 1'b0;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [7:0]  alu_opcode;
  logic        alu_carry, alu_flag, alu_low, alu_negative, alu_zero;
  logic [4:0]  psr;
  logic        done;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.REGS(16), .WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_rdest(instr_rdest), .instr_rsrc(instr_rsrc),
    .instr_imm(instr_imm), .instr_immval(instr_immval), .instr_wb(instr_wb), .instr_ld(instr_ld),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_c(alu_c),
    .alu_carry(alu_carry), .alu_flag(alu_flag), .alu_low(alu_low),
    .alu_negative(alu_negative), .alu_zero(alu_zero),
    .psr(psr), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ADD: C=carry out, F=signed overflow. CMP: C=borrow, F=signed less, L=unsigned less.
  always_comb begin
    alu_c     = '0;
    alu_carry = 1'b0;
    alu_flag  = 1'b0;
    alu_low   = 1'b0;
    case (alu_opcode)
      OP_ADD: begin
        {alu_carry, alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_flag = (alu_a[15] == alu_b[15]) && (alu_c[15] != alu_a[15]);
      end
      OP_CMP: begin
        alu_c     = alu_a - alu_b;
        alu_carry = alu_a < alu_b;
        alu_flag  = $signed(alu_a) < $signed(alu_b);
        alu_low   = alu_a < alu_b;
      end
      default: ;
    endcase
    alu_negative = alu_c[15];
    alu_zero     = (alu_c == 16'h0000);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [15:0] exp);
    dbg_addr = idx;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic drive(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic imm, input logic [7:0] iv, input logic wb, input logic ld);
    instr_opcode = op; instr_rdest = rd; instr_rsrc = rs;
    instr_imm = imm; instr_immval = iv; instr_wb = wb; instr_ld = ld;
  endtask

  // Issue one instruction from a negedge and follow it to retirement, checking done timing.
  task automatic run_instr(input string tag, input logic [7:0] op, input logic [3:0] rd,
                           input logic [3:0] rs, input logic imm, input logic [7:0] iv,
                           input logic wb, input logic ld);
    int guard = 0;
    while (!instr_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, {15'b0, instr_ready}, 16'h0001);
    drive(op, rd, rs, imm, iv, wb, ld);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_done_exec"}, {15'b0, done}, 16'h0000);
    @(negedge clk);
    chk({tag, "_done_wb"}, {15'b0, done}, 16'h0001);
    @(negedge clk);
    chk({tag, "_done_after"}, {15'b0, done}, 16'h0000);
  endtask

  logic [7:0] hs_op  [4];
  logic [3:0] hs_rd  [4];
  logic [3:0] hs_rs  [4];
  logic       hs_imm [4];
  logic [7:0] hs_iv  [4];
  logic       hs_wb  [4];
  logic       hs_ld  [4];
  int         acc    [4];

  initial begin
    // reset state
    #12;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) chk_reg("reset_reg", i[3:0], 16'h0000);
    chk("reset_psr", {11'b0, psr}, 16'h0000);
    chk("reset_ready", {15'b0, instr_ready}, 16'h0001);
    chk("reset_done", {15'b0, done}, 16'h0000);
    chk("reset_alu_a", alu_a, 16'h0000);
    chk("reset_alu_op", {8'b0, alu_opcode}, 16'h0000);

    // reset during EXEC of ld R3<-0x7F drops the write
    drive(8'h00, 4'd3, 4'd0, 1'b0, 8'h7F, 1'b0, 1'b1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_exec_ready", {15'b0, instr_ready}, 16'h0001);
    chk("rst_exec_done", {15'b0, done}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_reg("rst_exec_r3", 4'd3, 16'h0000);
    chk("rst_exec_ready2", {15'b0, instr_ready}, 16'h0001);

    // load then add
    run_instr("ld_r1", 8'h00, 4'd1, 4'd0, 1'b0, 8'h45, 1'b0, 1'b1);
    chk_reg("ld_r1_val", 4'd1, 16'h0045);
    chk("ld_psr_unchanged", {11'b0, psr}, 16'h0000);
    run_instr("ld_r2", 8'h00, 4'd2, 4'd0, 1'b0, 8'h80, 1'b0, 1'b1);
    chk_reg("ld_r2_val", 4'd2, 16'hFF80);
    run_instr("add_r1_r2", OP_ADD, 4'd1, 4'd2, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_reg("add_r1_val", 4'd1, 16'hFFC5);
    chk("add_r1_psr", {11'b0, psr}, 16'h0002);

    // immediate -1 added to 1 wraps to zero with carry
    run_instr("ld_r4", 8'h00, 4'd4, 4'd0, 1'b0, 8'h01, 1'b0, 1'b1);
    run_instr("addi_r4", OP_ADD, 4'd4, 4'd9, 1'b1, 8'hFF, 1'b1, 1'b0);
    chk_reg("addi_r4_val", 4'd4, 16'h0000);
    chk("addi_r4_psr", {11'b0, psr}, 16'h0011);

    // compare without writeback
    run_instr("ld_r5", 8'h00, 4'd5, 4'd0, 1'b0, 8'h10, 1'b0, 1'b1);
    run_instr("ld_r6", 8'h00, 4'd6, 4'd0, 1'b0, 8'h20, 1'b0, 1'b1);
    run_instr("cmp_r5_r6", OP_CMP, 4'd5, 4'd6, 1'b0, 8'h00, 1'b0, 1'b0);
    chk_reg("cmp_r5_keep", 4'd5, 16'h0010);
    chk("cmp_psr", {11'b0, psr}, 16'h001E);

    // rdest==rsrc: build 0x4000 by doubling, then one more doubling to 0x8000
    run_instr("ld_r7", 8'h00, 4'd7, 4'd0, 1'b0, 8'h40, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) run_instr("dbl_r7", OP_ADD, 4'd7, 4'd7, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_reg("r7_pre", 4'd7, 16'h4000);
    run_instr("add_r7_r7", OP_ADD, 4'd7, 4'd7, 1'b0, 8'h00, 1'b1, 1'b0);
    chk_reg("r7_val", 4'd7, 16'h8000);
    chk("r7_psr", {11'b0, psr}, 16'h000A);

    // valid held high across four back-to-back instructions
    hs_op  = '{8'h00, 8'h00, OP_ADD, OP_ADD};
    hs_rd  = '{4'd8, 4'd9, 4'd8, 4'd8};
    hs_rs  = '{4'd0, 4'd0, 4'd9, 4'd0};
    hs_imm = '{1'b0, 1'b0, 1'b0, 1'b1};
    hs_iv  = '{8'h03, 8'h05, 8'h00, 8'h02};
    hs_wb  = '{1'b0, 1'b0, 1'b1, 1'b1};
    hs_ld  = '{1'b1, 1'b1, 1'b0, 1'b0};
    begin
      int k = 0;
      int guard = 0;
      drive(hs_op[0], hs_rd[0], hs_rs[0], hs_imm[0], hs_iv[0], hs_wb[0], hs_ld[0]);
      instr_valid = 1'b1;
      while (k < 4 && guard < 40) begin
        @(negedge clk);
        guard++;
        if (instr_ready) begin
          acc[k] = cyc;
          @(posedge clk);
          k++;
          #1;
          if (k < 4) drive(hs_op[k], hs_rd[k], hs_rs[k], hs_imm[k], hs_iv[k], hs_wb[k], hs_ld[k]);
          else instr_valid = 1'b0;
        end
      end
      instr_valid = 1'b0;
      chk("hs_accepts", k[15:0], 16'd4);
      for (int i = 0; i < 3; i++) chk("hs_spacing", 16'(acc[i+1] - acc[i]), 16'd3);
    end
    repeat (3) @(negedge clk);
    chk_reg("hs_r8", 4'd8, 16'h000A);
    chk_reg("hs_r9", 4'd9, 16'h0005);
    chk("hs_psr", {11'b0, psr}, 16'h0000);
    chk("hs_ready_end", {15'b0, instr_ready}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
